// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// the instruction-fetch port and the data port of the pipelined core.
// Data has fixed priority over fetch. A granted request is latched and held
// on the memory side until mem_ack. The owner's ready then pulses for one
// cycle with the registered read data.
//
// Optional build macro ARB_PERF_CNT_EN adds the perf_stall_cnt and
// perf_conflict_cnt counter outputs.
//
// Handshake: a requester raises if_req (or d_rd/d_wr) and holds it, with
// stable address/data, until it sees its ready pulse. The ready cycle is an
// IDLE cycle, so a request still high in that cycle is taken as a new one.
// On the memory side, mem_en and its address/data/we stay stable from grant
// until a one-cycle mem_ack. mem_rdata is valid only with mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        fsm_state,
  output logic              stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic                if_ready_n, d_ready_n;
  logic [DATA_W-1:0]   if_rdata_n, d_rdata_n;
  logic                d_req;

  // A simultaneous read and write is illegal; d_wr wins, so it becomes a write.
  assign d_req     = d_rd | d_wr;
  assign fsm_state = state;

  // Freeze the pipeline while a request is pending and not completing now.
  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  // Next-state and next-output logic; everything defaults to hold, ready to 0.
  always_comb begin
    state_n     = state;
    mem_en_n    = mem_en;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_ready_n  = 1'b0;
    d_ready_n   = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    case (state)
      IDLE: begin
        // Any mem_ack seen here belongs to no access and is dropped.
        if (d_req) begin
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          mem_we_n    = d_wr;
          mem_en_n    = 1'b1;
          state_n     = D_ACC;
        end else if (if_req) begin
          mem_addr_n  = if_addr;
          mem_we_n    = 1'b0;
          mem_en_n    = 1'b1;
          state_n     = I_ACC;
        end
      end
      D_ACC: begin
        if (mem_ack) begin
          mem_en_n  = 1'b0;
          mem_we_n  = 1'b0;
          d_ready_n = 1'b1;
          state_n   = IDLE;
          if (!mem_we) d_rdata_n = mem_rdata;
        end
      end
      I_ACC: begin
        if (mem_ack) begin
          mem_en_n   = 1'b0;
          mem_we_n   = 1'b0;
          if_ready_n = 1'b1;
          if_rdata_n = mem_rdata;
          state_n    = IDLE;
        end
      end
      default: begin
        mem_en_n = 1'b0;
        mem_we_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_ready  <= if_ready_n;
      d_ready   <= d_ready_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Free-running, wrapping counters of stall cycles and IDLE-cycle contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (if_req && d_req && (state == IDLE))
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against
// a variable-latency memory model and a per-port expected-data queue.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_D    = 2'd1;
  localparam logic [1:0] S_I    = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_rd, d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    fsm_state;
  logic          stall;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .fsm_state(fsm_state), .stall(stall)
`ifdef ARB_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            mem_lat  = 1;
  int            model_cnt = 0;
  bit            mem_model_on = 1'b1;
  logic          force_ack = 1'b0;
  logic [DW-1:0] force_rdata = '0;
  logic [DW-1:0] d_shadow = '0;
  int            tb_stall_cnt = 0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    case (a)
      32'h0000_0010: mem_model = 32'h8C01_0004;
      32'h0000_0100: mem_model = 32'hDEAD_BEEF;
      default:       mem_model = {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks mem_lat cycles after it first sees mem_en.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_model_on) begin
        mem_ack   = force_ack;
        mem_rdata = force_rdata;
        model_cnt = 0;
      end else if (rst) begin
        mem_ack   = 1'b0;
        model_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_en) begin
        if (model_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
          model_cnt = 0;
        end else begin
          model_cnt++;
        end
      end
    end
  end

  // Scoreboard: every ready pulse pops and compares one expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (if_ready) begin
        if (if_exp_q.size() == 0) check("if_spurious_ready", if_ready, 1'b0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (d_ready) begin
        if (d_exp_q.size() == 0) check("d_spurious_ready", d_ready, 1'b0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic drive_reset();
    rst = 1'b1;
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_exp_q.delete(); d_exp_q.delete();
    d_shadow = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input bit f, input bit rd, input bit wr,
                       input logic [AW-1:0] fa, input logic [AW-1:0] da,
                       input logic [DW-1:0] wd);
    if (f) begin
      if_req = 1'b1; if_addr = fa;
      if_exp_q.push_back(mem_model(fa));
    end
    if (rd || wr) begin
      d_rd = rd; d_wr = wr; d_addr = da; d_wdata = wd;
      if (!wr) d_shadow = mem_model(da);
      d_exp_q.push_back(d_shadow);
    end
  endtask

  task automatic run_until_done(input int budget, input string tag);
    bit if_done, d_done;
    if_done = !if_req;
    d_done  = !(d_rd || d_wr);
    for (int c = 0; c < budget && !(if_done && d_done); c++) begin
      @(negedge clk);
      if (if_ready && if_req) begin if_req = 1'b0; if_done = 1'b1; end
      if (d_ready && (d_rd || d_wr)) begin d_rd = 1'b0; d_wr = 1'b0; d_done = 1'b1; end
    end
    check({tag, "_done"}, {62'd0, if_done, d_done}, 64'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    drive_reset();
    #1;
    check("rst_state", fsm_state, S_IDLE);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    check("rst_ready", {if_ready, d_ready}, 2'b00);

    // Fetch only, 1-cycle memory latency.
    mem_lat = 1;
    @(negedge clk); issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0); #1;
    check("t1_stall_c0", stall, 1'b1);
    check("t1_en_c0", mem_en, 1'b0);
    @(negedge clk); #1;
    check("t1_en_c1", mem_en, 1'b1);
    check("t1_addr_c1", mem_addr, 32'h10);
    check("t1_we_c1", mem_we, 1'b0);
    check("t1_state_c1", fsm_state, S_I);
    check("t1_stall_c1", stall, 1'b1);
    @(negedge clk); #1;
    check("t1_stall_c2", stall, 1'b1);
    @(negedge clk); #1;
    check("t1_ready_c3", if_ready, 1'b1);
    check("t1_rdata_c3", if_rdata, 32'h8C01_0004);
    check("t1_stall_c3", stall, 1'b0);
    if_req = 1'b0;
    @(negedge clk); #1;
    check("t1_ready_c4", if_ready, 1'b0);
    check("t1_state_c4", fsm_state, S_IDLE);

    // Simultaneous fetch and data read: data first, fetch granted in d_ready cycle.
    drive_reset();
    tb_stall_cnt = 0;
    @(negedge clk); issue(1'b1, 1'b1, 1'b0, 32'h20, 32'h100, 32'h0); #1;
    if (stall) tb_stall_cnt++;
    check("t2_stall_c0", stall, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      if (stall) tb_stall_cnt++;
      check($sformatf("t2_stall_c%0d", c), stall, (c < 6) ? 1'b1 : 1'b0);
      if (c == 1) begin
        check("t2_state_c1", fsm_state, S_D);
        check("t2_addr_c1", mem_addr, 32'h100);
      end
      if (c == 3) begin
        check("t2_dready_c3", d_ready, 1'b1);
        d_rd = 1'b0;
      end
      if (c == 4) begin
        check("t2_state_c4", fsm_state, S_I);
        check("t2_addr_c4", mem_addr, 32'h20);
      end
      if (c == 6) begin
        check("t2_iready_c6", if_ready, 1'b1);
        if_req = 1'b0;
      end
    end
`ifdef ARB_PERF_CNT_EN
    check("t2_perf_stall", perf_stall_cnt, tb_stall_cnt);
    check("t2_perf_conflict", perf_conflict_cnt, 32'd1);
`endif

    // Write with 4-cycle latency; request-side inputs change mid-access.
    mem_lat = 4;
    @(negedge clk); issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h40, 32'h1234_5678);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin d_addr = 32'hFFC; d_wdata = 32'h0; end
      check($sformatf("t3_en_we_c%0d", c), {mem_en, mem_we}, 2'b11);
      check($sformatf("t3_addr_c%0d", c), mem_addr, 32'h40);
      check($sformatf("t3_wdata_c%0d", c), mem_wdata, 32'h1234_5678);
    end
    @(negedge clk); #1;
    check("t3_dready_c6", d_ready, 1'b1);
    check("t3_drdata_kept", d_rdata, 32'hDEAD_BEEF);
    d_wr = 1'b0;
    @(negedge clk); #1;
    check("t3_dready_c7", d_ready, 1'b0);
    check("t3_en_c7", mem_en, 1'b0);

    // Fetch address changes mid-access; mem_addr must hold the latched value.
    mem_lat = 3;
    @(negedge clk); issue(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0);
    @(negedge clk); #1;
    check("t4_addr_c1", mem_addr, 32'h30);
    @(negedge clk); if_addr = 32'h999; #1;
    @(negedge clk); #1;
    check("t4_addr_c3", mem_addr, 32'h30);
    check("t4_en_c3", mem_en, 1'b1);
    run_until_done(20, "t4");

    // Reset in D_ACC followed by a late ack.
    mem_model_on = 1'b0;
    force_ack = 1'b0;
    @(negedge clk); issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0);
    @(negedge clk); #1;
    check("t5_state_dacc", fsm_state, S_D);
    rst = 1'b1; d_rd = 1'b0;
    if_exp_q.delete(); d_exp_q.delete(); d_shadow = '0;
    #1; force_ack = 1'b1; force_rdata = 32'hBAD0_BAD0;
    @(negedge clk); rst = 1'b0;
    #2; force_ack = 1'b0;
    @(negedge clk); #1;
    check("t5_state", fsm_state, S_IDLE);
    check("t5_en_we", {mem_en, mem_we}, 2'b00);
    check("t5_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
    check("t5_ready", {if_ready, d_ready}, 2'b00);
    check("t5_rdata", {if_rdata, d_rdata}, 64'h0);
    @(negedge clk); #1;
    check("t5_ready_late", {if_ready, d_ready}, 2'b00);
    mem_model_on = 1'b1;

    // Random mix of fetch, read, write and concurrent requests.
    for (int i = 0; i < 12; i++) begin
      int kind;
      logic [AW-1:0] fa, da;
      kind = $urandom_range(0, 4);
      mem_lat = $urandom_range(1, 4);
      fa = AW'($urandom_range(0, 255)) << 2;
      da = AW'($urandom_range(0, 255)) << 2;
      @(negedge clk);
      case (kind)
        0: issue(1'b1, 1'b0, 1'b0, fa, da, 32'h0);
        1: issue(1'b0, 1'b1, 1'b0, fa, da, 32'h0);
        2: issue(1'b0, 1'b0, 1'b1, fa, da, $urandom);
        3: issue(1'b1, 1'b1, 1'b0, fa, da, 32'h0);
        default: issue(1'b1, 1'b1, 1'b1, fa, da, $urandom);
      endcase
      run_until_done(40, $sformatf("rnd%0d", i));
    end

    @(negedge clk); @(negedge clk);
    check("if_q_empty", if_exp_q.size(), 0);
    check("d_q_empty", d_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
